// File: rtl/fetch_pc_unit_if.sv
// Fetch control/status bundle between decode/execute (master) and the PC unit (slave).
interface fetch_pc_unit_if #(
    parameter int PC_BITS  = 12,
    parameter int OFF_BITS = 8
);
    logic                start;
    logic                stall;
    logic                jump_en;
    logic [PC_BITS-1:0]  jump_target;
    logic                br_taken;
    logic [OFF_BITS-1:0] br_offset;
    logic                halt;
    logic [PC_BITS-1:0]  pc;
    logic                running;
    logic                done;
    logic                wrap_err;
    logic [15:0]         instr_count;

    modport master (
        output start, stall, jump_en, jump_target, br_taken, br_offset, halt,
        input  pc, running, done, wrap_err, instr_count
    );

    modport slave (
        input  start, stall, jump_en, jump_target, br_taken, br_offset, halt,
        output pc, running, done, wrap_err, instr_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter / fetch sequencer (IDLE -> RUN -> DONE).
// Optional retired-instruction counter enabled by FETCH_INSTR_COUNT_EN.
module fetch_pc_unit #(
    parameter int                 PC_BITS    = 12,
    parameter logic [PC_BITS-1:0] START_ADDR = '0,
    parameter int                 OFF_BITS   = 8
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_BITS-1:0] r_pc;
    logic [PC_BITS-1:0] w_pc_nxt;
    logic               r_wrap_err;
    logic               w_wrap_nxt;
    logic               w_restart;
    logic               w_retire;
    logic [PC_BITS-1:0] w_off_ext;
    logic [PC_BITS-1:0] w_pc_inc;
    logic [PC_BITS-1:0] w_pc_br;

    assign w_off_ext = PC_BITS'($signed(bus.br_offset));
    assign w_pc_inc  = r_pc + PC_BITS'(1);
    assign w_pc_br   = r_pc + w_off_ext;
    assign w_retire  = (r_state == ST_RUN) && !bus.stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= START_ADDR;
            r_wrap_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_wrap_err <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_wrap_nxt  = r_wrap_err;
        w_restart   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pc_nxt = START_ADDR;
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_restart   = 1'b1;
                end
            end
            ST_RUN: begin
                // stall outranks halt/jump/branch; priority halt > jump > branch > increment
                if (!bus.stall) begin
                    if (bus.halt) begin
                        w_state_nxt = ST_DONE;
                    end else if (bus.jump_en) begin
                        w_pc_nxt = bus.jump_target;
                    end else if (bus.br_taken) begin
                        w_pc_nxt = w_pc_br;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                        if (r_pc == '1) begin
                            w_wrap_nxt = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = START_ADDR;
                    w_wrap_nxt  = 1'b0;
                    w_restart   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = START_ADDR;
            end
        endcase
    end

`ifdef FETCH_INSTR_COUNT_EN
    logic [15:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_instr_count <= '0;
        end else if (w_retire && (r_instr_count != '1)) begin
            r_instr_count <= r_instr_count + 16'd1;
        end
    end

    assign bus.instr_count = r_instr_count;
`else
    logic w_unused_retire;
    logic w_unused_restart;
    assign w_unused_retire  = w_retire;
    assign w_unused_restart = w_restart;
    assign bus.instr_count  = '0;
`endif

    assign bus.pc       = r_pc;
    assign bus.running  = (r_state == ST_RUN);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.wrap_err = r_wrap_err;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit (PC_BITS=12, OFF_BITS=8, START_ADDR=0).
module tb_fetch_pc_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

`ifdef FETCH_INSTR_COUNT_EN
    localparam int EXP_CNT21 = 21;
`else
    localparam int EXP_CNT21 = 0;
`endif

    fetch_pc_unit_if #(.PC_BITS(12), .OFF_BITS(8)) bus ();

    fetch_pc_unit #(
        .PC_BITS   (12),
        .START_ADDR(12'h000),
        .OFF_BITS  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.jump_en     = 1'b0;
        bus.jump_target = '0;
        bus.br_taken    = 1'b0;
        bus.br_offset   = '0;
        bus.halt        = 1'b0;
    endtask

    task automatic jump_to(input logic [11:0] tgt);
        bus.jump_en     = 1'b1;
        bus.jump_target = tgt;
        tick();
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear_inputs();

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_pc", 32'(bus.pc), 32'h0);
        check("rst_running", 32'(bus.running), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_wrap", 32'(bus.wrap_err), 32'h0);
        check("rst_cnt", 32'(bus.instr_count), 32'h0);

        // IDLE holds without start
        reset = 1'b0;
        tick();
        check("idle_pc", 32'(bus.pc), 32'h0);
        check("idle_running", 32'(bus.running), 32'h0);

        // Start, then straight increment
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_pc", 32'(bus.pc), 32'h0);
        check("start_running", 32'(bus.running), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("inc_pc", 32'(bus.pc), 32'(i));
        end
        check("inc_done", 32'(bus.done), 32'h0);

        // Jump beats branch
        jump_to(12'd10);
        check("jmp10_pc", 32'(bus.pc), 32'd10);
        bus.jump_en     = 1'b1;
        bus.jump_target = 12'h200;
        bus.br_taken    = 1'b1;
        bus.br_offset   = 8'hFD;
        tick();
        clear_inputs();
        check("jmp_prio_pc", 32'(bus.pc), 32'h200);

        // Negative branch from 10
        jump_to(12'd10);
        bus.br_taken  = 1'b1;
        bus.br_offset = 8'hFD;
        tick();
        clear_inputs();
        check("br_neg_pc", 32'(bus.pc), 32'd7);

        // Positive branch from 7 by +0x25
        bus.br_taken  = 1'b1;
        bus.br_offset = 8'h25;
        tick();
        clear_inputs();
        check("br_pos_pc", 32'(bus.pc), 32'd44);

        // Branch wrapping below zero is silent
        jump_to(12'd2);
        bus.br_taken  = 1'b1;
        bus.br_offset = 8'hFB;
        tick();
        clear_inputs();
        check("br_wrap_pc", 32'(bus.pc), 32'd4093);
        check("br_wrap_flag", 32'(bus.wrap_err), 32'h0);

        // Increment wrap sets sticky flag
        jump_to(12'hFFF);
        check("top_pc", 32'(bus.pc), 32'hFFF);
        tick();
        check("wrap_pc", 32'(bus.pc), 32'h0);
        check("wrap_flag", 32'(bus.wrap_err), 32'h1);
        tick();
        check("wrap_sticky_pc", 32'(bus.pc), 32'h1);
        check("wrap_sticky", 32'(bus.wrap_err), 32'h1);

        // start mid-RUN ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("midstart_pc", 32'(bus.pc), 32'h2);
        check("midstart_running", 32'(bus.running), 32'h1);

        // Halt at pc=2 -> DONE
        bus.halt = 1'b1;
        tick();
        clear_inputs();
        check("halt_done", 32'(bus.done), 32'h1);
        check("halt_running", 32'(bus.running), 32'h0);
        check("halt_pc", 32'(bus.pc), 32'h2);
        check("halt_wrap", 32'(bus.wrap_err), 32'h1);

        // DONE ignores control inputs
        bus.jump_en     = 1'b1;
        bus.jump_target = 12'h123;
        bus.br_taken    = 1'b1;
        bus.br_offset   = 8'h10;
        bus.stall       = 1'b1;
        tick();
        clear_inputs();
        check("done_hold_pc", 32'(bus.pc), 32'h2);
        check("done_hold", 32'(bus.done), 32'h1);

        // Restart from DONE clears flags
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("restart_pc", 32'(bus.pc), 32'h0);
        check("restart_done", 32'(bus.done), 32'h0);
        check("restart_running", 32'(bus.running), 32'h1);
        check("restart_wrap", 32'(bus.wrap_err), 32'h0);
        check("restart_cnt", 32'(bus.instr_count), 32'h0);

        // Straight run 0..20
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("run20_pc", 32'(bus.pc), 32'(i));
        end

        // Stall outranks halt
        bus.stall = 1'b1;
        bus.halt  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", 32'(bus.pc), 32'd20);
            check("stall_running", 32'(bus.running), 32'h1);
        end
        bus.stall = 1'b0;
        tick();
        clear_inputs();
        check("halt20_done", 32'(bus.done), 32'h1);
        check("halt20_running", 32'(bus.running), 32'h0);
        check("halt20_pc", 32'(bus.pc), 32'd20);
        check("halt20_cnt", 32'(bus.instr_count), 32'(EXP_CNT21));

        // Restart, set wrap_err, then reset mid-RUN with a jump pending
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        jump_to(12'hFFF);
        tick();
        check("pre_rst_wrap", 32'(bus.wrap_err), 32'h1);
        jump_to(12'd37);
        check("pre_rst_pc", 32'(bus.pc), 32'd37);
        reset           = 1'b1;
        bus.jump_en     = 1'b1;
        bus.jump_target = 12'h123;
        tick();
        reset = 1'b0;
        clear_inputs();
        check("midrst_pc", 32'(bus.pc), 32'h0);
        check("midrst_running", 32'(bus.running), 32'h0);
        check("midrst_done", 32'(bus.done), 32'h0);
        check("midrst_wrap", 32'(bus.wrap_err), 32'h0);
        check("midrst_cnt", 32'(bus.instr_count), 32'h0);
        tick();
        check("post_rst_pc", 32'(bus.pc), 32'h0);
        check("post_rst_running", 32'(bus.running), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
